// File: rtl/mem_ctlr_responder.sv
// mem_ctlr_responder: memory-controller stand-in for the cache <-> controller bus.
// It accepts at most one LOAD or STORE per cycle and grants a 4-bit tag in the same cycle.
// It returns {tag, data} exactly MEM_LATENCY cycles later, strictly in accept order.
// The backing store is a plain 64-bit word array. It is never reset, so a bench can preload it.
module mem_ctlr_responder #(
  parameter int MEM_LATENCY = 4,  // 1..14 so that no tag can alias while in flight
  parameter int MEM_AW      = 8   // backing store holds 2**MEM_AW 64-bit words
) (
  input  logic        clock,
  input  logic        reset,               // asynchronous, active-low
  input  logic [1:0]  proc2ctlr_command,
  input  logic [31:0] proc2ctlr_addr,
  input  logic [63:0] proc2ctlr_data,
  input  logic        stall_in,
  output logic [3:0]  ctlr2proc_response,
  output logic [63:0] ctlr2proc_data,
  output logic [3:0]  ctlr2proc_tag
);

  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic [63:0]       r_mem       [0:(1<<MEM_AW)-1];
  logic [3:0]        r_tag_cnt;
  // Return pipeline. A tag of 0 marks an idle stage, and idle stages always carry zero data.
  logic [3:0]        r_tag_pipe  [0:MEM_LATENCY-1];
  logic [63:0]       r_data_pipe [0:MEM_LATENCY-1];

  logic              w_is_load;
  logic              w_is_store;
  logic              w_accept;
  logic [MEM_AW-1:0] w_idx;
  logic              w_unused_addr;

  // Command 3 (reserved) and BUS_NONE both fall through as "not a request".
  assign w_is_load  = (proc2ctlr_command == BUS_LOAD);
  assign w_is_store = (proc2ctlr_command == BUS_STORE);

  // Reset gates the accept path so that no grant is visible while reset is held.
  assign w_accept   = reset && !stall_in && (w_is_load || w_is_store);

  assign ctlr2proc_response = w_accept ? r_tag_cnt : 4'd0;

  // Word index. Byte-offset bits and address bits above the store depth are ignored.
  assign w_idx         = proc2ctlr_addr[MEM_AW+2:3];
  assign w_unused_addr = ^{proc2ctlr_addr[31:MEM_AW+3], proc2ctlr_addr[2:0]};

  // The last pipeline stage is itself the registered output.
  assign ctlr2proc_tag  = r_tag_pipe[MEM_LATENCY-1];
  assign ctlr2proc_data = r_data_pipe[MEM_LATENCY-1];

  // Tag counter: advances only on an accept and cycles 1..15, so tag 0 is never issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag_cnt <= 4'd1;
    end else if (w_accept) begin
      r_tag_cnt <= (r_tag_cnt == 4'd15) ? 4'd1 : r_tag_cnt + 4'd1;
    end
  end

  // Backing store write port. It is written at the accept edge of a STORE.
  always_ff @(posedge clock) begin
    if (w_accept && w_is_store) begin
      r_mem[w_idx] <= proc2ctlr_data;
    end
  end

  // Return pipeline: stage 0 captures the grant, and loads read the store at that same edge.
  // Because the read happens at the accept edge, a store accepted one cycle earlier is already
  // visible to the load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_tag_pipe[i]  <= 4'd0;
        r_data_pipe[i] <= 64'd0;
      end
    end else begin
      r_tag_pipe[0]  <= w_accept ? r_tag_cnt : 4'd0;
      r_data_pipe[0] <= (w_accept && w_is_load) ? r_mem[w_idx] : 64'd0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_tag_pipe[i]  <= r_tag_pipe[i-1];
        r_data_pipe[i] <= r_data_pipe[i-1];
      end
    end
  end

endmodule
